// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU: answers the hazard unit's level
// start with a one-cycle ready pulse carrying {remainder, quotient}.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int WK_W  = 2*DATA_W + 1;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [WK_W-1:0]      work, work_nxt;
  logic [DATA_W-1:0]    dvs, dvs_nxt;
  logic                 neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0]  result_nxt;
  logic                 ready_nxt;

  logic [DATA_W-1:0]    abs_a, abs_b, q_mag, r_mag, q_fin, r_fin;
  logic [WK_W-1:0]      shifted, step_w;
  logic [DATA_W:0]      diff;
  logic                 unused_work_msb;

  // Magnitudes and sign flags are taken from the operands only at ON entry.
  assign abs_a = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign abs_b = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // One restoring step: shift in, trial-subtract, keep the difference if no borrow.
  assign shifted = {work[WK_W-2:0], 1'b0};
  assign diff    = shifted[WK_W-1:DATA_W] - {1'b0, dvs};
  assign step_w  = diff[DATA_W] ? shifted : {diff, shifted[DATA_W-1:1], 1'b1};

  assign q_mag = work[DATA_W-1:0];
  assign r_mag = work[2*DATA_W-1:DATA_W];
  assign q_fin = neg_q ? -q_mag : q_mag;
  assign r_fin = neg_r ? -r_mag : r_mag;

  // Restored partial remainder never exceeds the divisor, so the top bit stays 0.
  assign unused_work_msb = work[WK_W-1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvs_nxt    = dvs;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result;
    ready_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          if (opdata2 == '0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt = ON;
            work_nxt  = {{(DATA_W+1){1'b0}}, abs_a};
            dvs_nxt   = abs_b;
            neg_q_nxt = signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_r_nxt = signed_div && opdata1[DATA_W-1];
            cnt_nxt   = '0;
          end
        end
      end
      BYZERO: begin
        if (annul || !start) begin
          state_nxt = IDLE;
        end else begin
          result_nxt = '0;
          ready_nxt  = 1'b1;
          state_nxt  = END;
        end
      end
      ON: begin
        if (annul || !start) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(DATA_W)) begin
          result_nxt = {r_fin, q_fin};
          ready_nxt  = 1'b1;
          state_nxt  = END;
        end else begin
          work_nxt = step_w;
          cnt_nxt  = cnt + 1'b1;
        end
      end
      END:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      work   <= work_nxt;
      dvs    <= dvs_nxt;
      neg_q  <= neg_q_nxt;
      neg_r  <= neg_r_nxt;
      result <= result_nxt;
      ready  <= ready_nxt;
    end
  end
endmodule
